// File: rtl/imm_ext_pkg.sv
// Shared definitions for immediate extension: mode encodings and default widths
// used by decode, the extension pipe and the ALU operand mux.
package imm_ext_pkg;

  localparam int DEF_IN_W     = 16;
  localparam int DEF_OUT_W    = 32;
  localparam int DEF_BR_SHIFT = 2;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Pure combinational mode arithmetic: turns an IN_W-bit immediate into an
// OUT_W-bit operand. OUT_W must be at least IN_W + BR_SHIFT.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int BR_SHIFT = DEF_BR_SHIFT
) (
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext
);

  logic signed [IN_W-1:0]  imm_s;
  logic signed [OUT_W-1:0] sext;

  assign imm_s = signed'(in_imm);
  // Sized cast of a signed operand replicates the sign bit into the upper bits.
  assign sext  = OUT_W'(imm_s);

  // Select the extension flavour; branch offsets drop shifted-out MSBs.
  always_comb begin
    ext = '0;
    case (in_mode)
      MODE_ZERO:   ext = OUT_W'(in_imm);
      MODE_SIGN:   ext = sext;
      MODE_UPPER:  ext = OUT_W'(in_imm) << (OUT_W - IN_W);
      MODE_BRANCH: ext = sext <<< BR_SHIFT;
      default:     ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender between decode and the ALU operand mux.
// Output register plus one skid entry: in_ready comes straight from a flop,
// so decode never sees a combinational path from out_ready.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int BR_SHIFT = DEF_BR_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  logic [OUT_W-1:0] ext_p0;
  logic [OUT_W-1:0] data_p1, sk_data_p1;
  logic [1:0]       mode_p1, sk_mode_p1;
  logic             vld_p1, sk_vld_p1;
  logic             acc, drn;

  imm_ext_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .in_imm  (in_imm),
    .in_mode (in_mode),
    .ext     (ext_p0)
  );

  assign in_ready = !sk_vld_p1;
  assign acc      = in_valid && in_ready;
  assign drn      = vld_p1 && out_ready;

  // ---- stage 0 -> 1: output register refills from skid first, then input ----
  // Input data is only captured on accept, so idle-cycle X never enters state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      mode_p1    <= '0;
      sk_vld_p1  <= 1'b0;
      sk_data_p1 <= '0;
      sk_mode_p1 <= '0;
    end else if (!vld_p1 || drn) begin
      if (sk_vld_p1) begin
        data_p1   <= sk_data_p1;
        mode_p1   <= sk_mode_p1;
        vld_p1    <= 1'b1;
        sk_vld_p1 <= 1'b0;
      end else if (acc) begin
        data_p1 <= ext_p0;
        mode_p1 <= in_mode;
        vld_p1  <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (acc) begin
      sk_data_p1 <= ext_p0;
      sk_mode_p1 <= in_mode;
      sk_vld_p1  <= 1'b1;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_mode  = mode_p1;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomised-stream bench for imm_extend_pipe at default widths.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  int errors = 0;
  int checks = 0;

  imm_extend_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference for the default 16->32, shift-2 configuration.
  function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] imm);
    case (m)
      2'd0:    return {16'h0000, imm};
      2'd1:    return {{16{imm[15]}}, imm};
      2'd2:    return {imm, 16'h0000};
      default: return {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  // Present one beat (in_ready expected high), clock it in, check it one cycle later.
  task automatic beat(input logic [1:0] m, input logic [15:0] imm,
                      input logic [31:0] exp, input string tag);
    in_valid = 1'b1;
    in_mode  = m;
    in_imm   = imm;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_mode"}, 32'(out_mode), 32'(m));
  endtask

  logic [33:0] sb[$];
  logic [33:0] head;
  int          sent;
  int          cycles;
  logic        held;
  logic        ir0;
  logic        acc_s, drn_s;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back sign extension, then the other modes and boundaries.
    out_ready = 1'b1;
    beat(2'd1, 16'h0001, 32'h00000001, "sign_pos");
    beat(2'd1, 16'hFFFF, 32'hFFFFFFFF, "sign_neg");
    beat(2'd0, 16'hFFFF, 32'h0000FFFF, "zero_ffff");
    beat(2'd2, 16'h1234, 32'h12340000, "upper_1234");
    beat(2'd2, 16'h8000, 32'h80000000, "upper_8000");
    beat(2'd3, 16'hFFFE, 32'hFFFFFFF8, "br_fffe");
    beat(2'd3, 16'h7FFF, 32'h0001FFFC, "br_7fff");
    beat(2'd3, 16'h8000, 32'hFFFE0000, "br_8000");
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_empty", 32'(out_valid), 32'd0);

    // Backpressure: fill output and skid, third beat must stall.
    out_ready = 1'b0;
    beat(2'd1, 16'h0005, 32'h00000005, "bp_5");
    in_imm = 16'h0006;
    check("bp_6_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_full_rdy", 32'(in_ready), 32'd0);
    check("bp_hold_a", out_data, 32'h00000005);
    in_imm = 16'h0007;
    @(posedge clk); #1;
    check("bp_stall_rdy", 32'(in_ready), 32'd0);
    check("bp_hold_b", out_data, 32'h00000005);
    check("bp_hold_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_no_comb", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("bp_out_6", out_data, 32'h00000006);
    check("bp_rdy_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_out_7", out_data, 32'h00000007);
    check("bp_out_7_vld", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_done", 32'(out_valid), 32'd0);

    // Random stream against the reference model, in order.
    sent   = 0;
    cycles = 0;
    held   = 1'b0;
    while ((sent < 100 || sb.size() != 0 || out_valid) && cycles < 3000) begin
      ir0 = in_ready;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!held) begin
        if (sent < 100 && $urandom_range(0, 9) < 7) begin
          in_valid = 1'b1;
          in_mode  = 2'($urandom_range(0, 3));
          in_imm   = 16'($urandom);
        end else begin
          in_valid = 1'b0;
          in_mode  = 2'bxx;
          in_imm   = 16'hxxxx;
        end
      end
      #1;
      check("st_rdy_no_comb", 32'(in_ready), 32'(ir0));
      @(negedge clk);
      acc_s = in_valid && in_ready;
      drn_s = out_valid && out_ready;
      if (drn_s) begin
        if (sb.size() == 0) begin
          check("st_spurious_beat", 32'(out_valid), 32'd0);
        end else begin
          head = sb.pop_front();
          check("st_data", out_data, head[31:0]);
          check("st_mode", 32'(out_mode), 32'(head[33:32]));
        end
      end
      if (acc_s) begin
        sb.push_back({in_mode, ref_ext(in_mode, in_imm)});
        sent++;
      end
      held = in_valid && !acc_s;
      @(posedge clk); #1;
      cycles++;
    end
    check("st_all_sent", 32'(sent), 32'd100);
    check("st_sb_empty", 32'(sb.size()), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset with both entries occupied.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_imm    = 16'h1111;
    @(posedge clk); #1;
    in_imm    = 16'h2222;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    check("rm_full_rdy", 32'(in_ready), 32'd0);
    check("rm_full_vld", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rm_async_vld", 32'(out_valid), 32'd0);
    check("rm_async_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rm_post_vld", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    beat(2'd2, 16'h00FF, 32'h00FF0000, "rm_upper");
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rm_final_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
